// File: rtl/tmds_decoder_if.sv
// Symbol/status bundle between a deserializer (master) and one TMDS channel decoder (slave).
interface tmds_decoder_if;
  logic [9:0] din;
  logic       bitslip;
  logic       locked;
  logic       de;
  logic [1:0] ctrl;
  logic [7:0] data;
  logic       err;

  modport master (
    output din,
    input  bitslip,
    input  locked,
    input  de,
    input  ctrl,
    input  data,
    input  err
  );

  modport slave (
    input  din,
    output bitslip,
    output locked,
    output de,
    output ctrl,
    output data,
    output err
  );
endinterface

// File: rtl/tmds_decoder.sv
// One TMDS receive channel: symbol register, 10b->8b decode, control-token detection and a
// word-alignment FSM that requests bit-slips until control tokens are seen reliably.
module tmds_decoder #(
  parameter int unsigned ALIGN_TOKENS  = 128,
  parameter int unsigned SEARCH_WINDOW = 4096,
  parameter int unsigned SLIP_WAIT     = 16
) (
  input logic           clk,
  input logic           rstn,
  tmds_decoder_if.slave bus
);

  localparam int unsigned RunW  = $clog2(ALIGN_TOKENS + 1);
  localparam int unsigned WinW  = $clog2(SEARCH_WINDOW + 1);
  localparam int unsigned WaitW = $clog2(SLIP_WAIT + 1);

  localparam logic [RunW-1:0]  RunMax   = RunW'(ALIGN_TOKENS);
  localparam logic [WinW-1:0]  WinLast  = WinW'(SEARCH_WINDOW - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(SLIP_WAIT - 1);

  localparam logic [1:0] StSearch = 2'd0;
  localparam logic [1:0] StSlip   = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;
  localparam logic [1:0] StLocked = 2'd3;

  logic [9:0]       r_s1;
  logic [1:0]       r_state;
  logic [RunW-1:0]  r_run;
  logic [WinW-1:0]  r_win;
  logic [WaitW-1:0] r_wait;
  logic             r_bitslip;
  logic             r_locked;
  logic             r_err;
  logic             r_de;
  logic [1:0]       r_ctrl;
  logic [7:0]       r_data;

  logic             w_tok;
  logic [1:0]       w_tok_ctrl;
  logic [7:0]       w_d;
  logic [7:0]       w_q;
  logic [1:0]       w_state_nxt;
  logic [RunW-1:0]  w_run_nxt;
  logic [RunW-1:0]  w_run_inc;
  logic [WinW-1:0]  w_win_nxt;
  logic [WaitW-1:0] w_wait_nxt;
  logic             w_bitslip_nxt;
  logic             w_err_nxt;

  always_comb begin
    w_tok      = 1'b1;
    w_tok_ctrl = 2'b00;
    unique case (r_s1)
      10'h354: w_tok_ctrl = 2'b00;
      10'h0AB: w_tok_ctrl = 2'b01;
      10'h154: w_tok_ctrl = 2'b10;
      10'h2AB: w_tok_ctrl = 2'b11;
      default: w_tok      = 1'b0;
    endcase
  end

  // Undo the optional DC-balance inversion, then the XOR/XNOR transition chain.
  always_comb begin
    w_d    = r_s1[9] ? ~r_s1[7:0] : r_s1[7:0];
    w_q    = '0;
    w_q[0] = w_d[0];
    for (int i = 1; i < 8; i++) begin
      w_q[i] = r_s1[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_win_nxt     = r_win;
    w_wait_nxt    = r_wait;
    w_bitslip_nxt = 1'b0;
    w_err_nxt     = 1'b0;
    w_run_inc     = (r_run == RunMax) ? r_run : r_run + 1'b1;
    w_run_nxt     = w_tok ? w_run_inc : '0;
    unique case (r_state)
      StSearch: begin
        w_win_nxt = r_win + 1'b1;
        // Lock takes priority over a slip falling due on the same edge.
        if (w_tok && (w_run_inc == RunMax)) begin
          w_state_nxt = StLocked;
          w_win_nxt   = '0;
        end else if (r_win == WinLast) begin
          w_state_nxt   = StSlip;
          w_bitslip_nxt = 1'b1;
          w_win_nxt     = '0;
          w_run_nxt     = '0;
        end
      end
      StSlip: begin
        w_state_nxt = StWait;
        w_wait_nxt  = '0;
        w_win_nxt   = '0;
        w_run_nxt   = '0;
      end
      StWait: begin
        w_win_nxt = '0;
        w_run_nxt = '0;
        if (r_wait == WaitLast) begin
          w_state_nxt = StSearch;
          w_wait_nxt  = '0;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end
      StLocked: begin
        if (w_tok) begin
          w_win_nxt = '0;
        end else if (r_win == WinLast) begin
          // Timeout drops back to searching; the next slip waits a full window.
          w_state_nxt = StSearch;
          w_err_nxt   = 1'b1;
          w_win_nxt   = '0;
          w_run_nxt   = '0;
        end else begin
          w_win_nxt = r_win + 1'b1;
        end
      end
      default: begin
        w_state_nxt = StSearch;
        w_win_nxt   = '0;
        w_run_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1      <= '0;
      r_state   <= StSearch;
      r_run     <= '0;
      r_win     <= '0;
      r_wait    <= '0;
      r_bitslip <= 1'b0;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_s1      <= bus.din;
      r_state   <= w_state_nxt;
      r_run     <= w_run_nxt;
      r_win     <= w_win_nxt;
      r_wait    <= w_wait_nxt;
      r_bitslip <= w_bitslip_nxt;
      r_locked  <= (w_state_nxt == StLocked);
      r_err     <= w_err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_de   <= 1'b0;
      r_ctrl <= 2'b00;
      r_data <= 8'h00;
    end else if (!r_locked) begin
      r_de <= 1'b0;
    end else if (w_tok) begin
      r_de   <= 1'b0;
      r_ctrl <= w_tok_ctrl;
    end else begin
      r_de   <= 1'b1;
      r_data <= w_q;
    end
  end

  assign bus.bitslip = r_bitslip;
  assign bus.locked  = r_locked;
  assign bus.err     = r_err;
  assign bus.de      = r_de;
  assign bus.ctrl    = r_ctrl;
  assign bus.data    = r_data;

  a_slip_err_excl: assert property (@(posedge clk) disable iff (!rstn) !(r_bitslip && r_err));

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: vector table for decode, hand sequences for alignment.
module tb_tmds_decoder;

  typedef struct {
    logic [9:0] din;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
  } vec_t;

  localparam int NVec = 11;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  tmds_decoder_if u_if ();
  tmds_decoder u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (u_if)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[NVec];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [9:0] v);
    u_if.din = v;
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_tok(input logic [9:0] v);
    return (v == 10'h354) || (v == 10'h0AB) || (v == 10'h154) || (v == 10'h2AB);
  endfunction

  function automatic logic [9:0] rand_sym();
    logic [9:0] v;
    do v = 10'($urandom_range(0, 1023)); while (is_tok(v));
    return v;
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] v, input int n);
    logic [9:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[8:0], r[9]};
    return r;
  endfunction

  // Reference TMDS encoder (transition minimisation; inversion chosen by caller).
  function automatic logic [9:0] tmds_enc(input logic [7:0] b, input logic inv);
    logic [8:0] qm;
    logic       use_xnor;
    int         n1;
    n1       = $countones(b);
    use_xnor = (n1 > 4) || ((n1 == 4) && (b[0] == 1'b0));
    qm[0]    = b[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
    qm[8] = ~use_xnor;
    return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
  endfunction

  task automatic check_zero(input string name);
    check(name, 32'({u_if.bitslip, u_if.locked, u_if.de, u_if.err, u_if.ctrl, u_if.data}), 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (3) step(rand_sym());
    rstn = 1'b1;
  endtask

  initial begin
    int bad;
    int nslip;
    int offset;
    int cyc;
    int t[3];

    vecs[0]  = '{10'h2FF, 1'b1, 2'b00, 8'hFE};
    vecs[1]  = '{10'h100, 1'b1, 2'b00, 8'h00};
    vecs[2]  = '{10'h0AB, 1'b0, 2'b01, 8'h00};
    vecs[3]  = '{10'h154, 1'b0, 2'b10, 8'h00};
    vecs[4]  = '{10'h2AB, 1'b0, 2'b11, 8'h00};
    vecs[5]  = '{10'h1FF, 1'b1, 2'b11, 8'h01};
    vecs[6]  = '{10'h0FF, 1'b1, 2'b11, 8'hFF};
    vecs[7]  = '{10'h155, 1'b1, 2'b11, 8'hFF};
    vecs[8]  = '{10'h354, 1'b0, 2'b00, 8'hFF};
    vecs[9]  = '{10'h203, 1'b1, 2'b00, 8'hFA};
    vecs[10] = '{10'h10F, 1'b1, 2'b00, 8'h11};

    // Reset values and the first slip after release.
    rstn     = 1'b0;
    u_if.din = '0;
    repeat (4) step(rand_sym());
    check_zero("reset_outputs");
    rstn = 1'b1;
    bad  = 0;
    for (int c = 1; c <= 4095; c++) begin
      step(rand_sym());
      if (u_if.locked || u_if.de || u_if.bitslip || u_if.err) bad++;
    end
    check("search_quiet", 32'(bad), 0);
    step(rand_sym());
    check("first_slip_4096", 32'(u_if.bitslip), 1);
    step(rand_sym());
    check("slip_one_cycle", 32'(u_if.bitslip), 0);

    // Lock on 128 tokens.
    do_reset();
    for (int c = 1; c <= 128; c++) step(10'h354);
    check("no_lock_at_127", 32'(u_if.locked), 0);
    step(10'h100);
    check("lock_edge", 32'({u_if.locked, u_if.de, u_if.ctrl}), 32'({1'b1, 1'b0, 2'b00}));
    step(10'h100);
    check("first_data", 32'({u_if.de, u_if.data}), 32'({1'b1, 8'h00}));

    // Vector table; outputs lag the driven symbol by one step here.
    for (int i = 0; i <= NVec; i++) begin
      step((i < NVec) ? vecs[i].din : 10'h100);
      if (i > 0) begin
        check($sformatf("vec%0d_de", i - 1), 32'(u_if.de), 32'(vecs[i-1].de));
        check($sformatf("vec%0d_ctrl", i - 1), 32'(u_if.ctrl), 32'(vecs[i-1].ctrl));
        check($sformatf("vec%0d_data", i - 1), 32'(u_if.data), 32'(vecs[i-1].data));
      end
    end

    // Byte sweep through the reference encoder.
    for (int b = 0; b <= 256; b++) begin
      step((b < 256) ? tmds_enc(8'(b), (b % 2) == 1) : 10'h100);
      if (b > 0) check($sformatf("sweep_%0d", b - 1), 32'({u_if.de, u_if.data}),
                       32'({1'b1, 8'(b - 1)}));
    end

    // Asynchronous reset while locked with non-zero data.
    #2 rstn = 1'b0;
    #1 check_zero("async_reset_locked");

    // Misaligned stream: three slips, 4113 cycles apart, then lock.
    do_reset();
    offset = 3;
    nslip  = 0;
    cyc    = 0;
    t      = '{0, 0, 0};
    while (!u_if.locked && cyc < 20000) begin
      step(rotl(10'h354, offset));
      cyc++;
      if (u_if.bitslip) begin
        if (nslip < 3) t[nslip] = cyc;
        nslip++;
        if (offset > 0) offset--;
      end
    end
    check("misalign_locked", 32'(u_if.locked), 1);
    check("misalign_slips", 32'(nslip), 3);
    check("misalign_first", 32'(t[0]), 4096);
    check("misalign_gap1", 32'(t[1] - t[0]), 4113);
    check("misalign_gap2", 32'(t[2] - t[1]), 4113);

    // Loss of lock after 4096 non-token symbols.
    do_reset();
    for (int c = 1; c <= 128; c++) step(10'h354);
    step(10'h100);
    bad = 0;
    for (int c = 130; c <= 4224; c++) begin
      step(10'h100);
      if (u_if.err || !u_if.locked) bad++;
    end
    check("locked_hold", 32'(bad), 0);
    step(10'h100);
    check("loss_err", 32'({u_if.err, u_if.locked}), 32'({1'b1, 1'b0}));
    step(10'h100);
    check("loss_after", 32'({u_if.err, u_if.de, u_if.bitslip}), 0);
    bad = 0;
    for (int c = 4227; c <= 8320; c++) begin
      step(10'h100);
      if (u_if.bitslip) bad++;
    end
    check("loss_no_slip", 32'(bad), 0);
    step(10'h100);
    check("loss_late_slip", 32'(u_if.bitslip), 1);

    // Tie: 128th token on the window's last edge.
    do_reset();
    for (int c = 1; c <= 3967; c++) step(10'h100);
    for (int c = 3968; c <= 4095; c++) step(10'h354);
    check("tie_pre", 32'(u_if.locked), 0);
    step(10'h100);
    check("tie_lock", 32'({u_if.locked, u_if.bitslip}), 32'({1'b1, 1'b0}));
    step(10'h100);
    check("tie_after", 32'({u_if.locked, u_if.bitslip}), 32'({1'b1, 1'b0}));

    // Reset during WAIT restarts the search window from zero.
    do_reset();
    for (int c = 1; c <= 4096; c++) step(10'h100);
    check("wait_slip", 32'(u_if.bitslip), 1);
    repeat (5) step(10'h100);
    #2 rstn = 1'b0;
    #1 check_zero("async_reset_wait");
    repeat (2) step(10'h100);
    rstn = 1'b1;
    cyc  = 0;
    for (int c = 1; c <= 4200; c++) begin
      step(10'h100);
      if (u_if.bitslip && cyc == 0) cyc = c;
    end
    check("wait_reset_restart", 32'(cyc), 4096);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
